// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data memory with optional wait states,
// MEM/WB register, and the forwarding taps consumed by the execute stage.
module mem_stage #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [15:0] aluOut,
  input  logic [15:0] writeData,
  input  logic [4:0]  regDst,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  output logic        stall,
  output logic [15:0] prevALURes,
  output logic [4:0]  rd_exmem,
  output logic        regWrite_exmem,
  output logic [15:0] prevMEMRes,
  output logic [4:0]  rd_memwb,
  output logic        regWrite_memwb
);

  // state   | meaning
  // S_READY | cnt == 0: EX/MEM entry completes on the next edge, upstream advances
  // S_WAIT  | cnt != 0: memory access still busy, upstream held

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic {S_READY, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             in_mem_op;
  logic             do_store;

  // memRead is not kept in EX/MEM: completion timing is fixed by cnt at
  // capture, and the read path is always live.
  logic [15:0] exmem_alu;
  logic [15:0] exmem_wd;
  logic [4:0]  exmem_rd;
  logic        exmem_rw;
  logic        exmem_mw;
  logic        exmem_m2r;

  logic [DEPTH_LOG2-1:0] addr;
  logic [15:0]           mem_rdata;
  logic [15:0]           mem [DEPTH] = '{default: 16'h0000};

  assign in_mem_op = ex_valid & (memRead | memWrite);
  assign addr      = exmem_alu[DEPTH_LOG2-1:0];
  assign mem_rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  always_comb begin
    state    = (cnt != '0) ? S_WAIT : S_READY;
    cnt_next = cnt;
    stall    = 1'b0;
    do_store = 1'b0;
    case (state)
      S_READY: begin
        cnt_next = in_mem_op ? CNT_LOAD : '0;
        do_store = exmem_mw;
      end
      S_WAIT: begin
        stall    = 1'b1;
        cnt_next = cnt - 1'b1;
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_alu <= '0;
      exmem_wd  <= '0;
      exmem_rd  <= '0;
      exmem_rw  <= 1'b0;
      exmem_mw  <= 1'b0;
      exmem_m2r <= 1'b0;
    end else if (!stall) begin
      exmem_alu <= aluOut;
      exmem_wd  <= writeData;
      exmem_rd  <= regDst;
      exmem_rw  <= regWrite & ex_valid;
      exmem_mw  <= memWrite & ex_valid;
      exmem_m2r <= memToReg;
    end
  end

  // Not reset: memory contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (!reset && do_store) begin
      mem[addr] <= exmem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prevMEMRes     <= '0;
      rd_memwb       <= '0;
      regWrite_memwb <= 1'b0;
    end else if (stall) begin
      rd_memwb       <= '0;
      regWrite_memwb <= 1'b0;
    end else begin
      prevMEMRes     <= exmem_m2r ? mem_rdata : exmem_alu;
      rd_memwb       <= exmem_rd;
      regWrite_memwb <= exmem_rw;
    end
  end

  assign prevALURes     = exmem_alu;
  assign rd_exmem       = exmem_rd;
  assign regWrite_exmem = exmem_rw;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instruction streams checked against a transaction-level memory model.
module tb_mem_stage;

  localparam int WS = 2;
  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [15:0] aluOut;
  logic [15:0] writeData;
  logic [4:0]  regDst;
  logic        regWrite, memRead, memWrite, memToReg;
  logic        stall;
  logic [15:0] prevALURes;
  logic [4:0]  rd_exmem;
  logic        regWrite_exmem;
  logic [15:0] prevMEMRes;
  logic [4:0]  rd_memwb;
  logic        regWrite_memwb;

  mem_stage #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .aluOut(aluOut),
    .writeData(writeData), .regDst(regDst), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .stall(stall), .prevALURes(prevALURes), .rd_exmem(rd_exmem),
    .regWrite_exmem(regWrite_exmem), .prevMEMRes(prevMEMRes),
    .rd_memwb(rd_memwb), .regWrite_memwb(regWrite_memwb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
  } instr_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem_model [1 << DL];
  logic        pend_rw;
  logic [4:0]  pend_rd;
  logic [15:0] pend_val;
  logic [15:0] last_memres;
  instr_t      cur;
  logic        cur_memop;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [15:0] a, input logic [15:0] w,
                                input logic [4:0] r, input logic rw, input logic mr,
                                input logic mw, input logic m2r);
    instr_t t;
    t.valid = v; t.alu = a; t.wd = w; t.rd = r;
    t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r;
    return t;
  endfunction

  task automatic apply(input instr_t t);
    ex_valid = t.valid; aluOut = t.alu; writeData = t.wd; regDst = t.rd;
    regWrite = t.rw; memRead = t.mr; memWrite = t.mw; memToReg = t.m2r;
  endtask

  task automatic scramble_inputs();
    ex_valid = 1'($urandom); aluOut = 16'($urandom); writeData = 16'($urandom);
    regDst = 5'($urandom); regWrite = 1'($urandom); memRead = 1'($urandom);
    memWrite = 1'($urandom); memToReg = 1'($urandom);
  endtask

  // Capture edge of t; also the completion edge of the previous instruction.
  task automatic capture(input instr_t t, input string nm);
    logic [7:0]  a;
    logic [15:0] rdval;
    apply(t);
    @(posedge clk); #1;
    cur = t;
    cur_memop = t.valid & (t.mr | t.mw);
    check({nm, " prevALURes"}, prevALURes, t.alu);
    check({nm, " rd_exmem"}, 16'(rd_exmem), 16'(t.rd));
    check({nm, " regWrite_exmem"}, 16'(regWrite_exmem), 16'(t.valid & t.rw));
    check({nm, " stall"}, 16'(stall), 16'(cur_memop && WS > 0));
    check({nm, " prev prevMEMRes"}, prevMEMRes, pend_val);
    check({nm, " prev rd_memwb"}, 16'(rd_memwb), 16'(pend_rd));
    check({nm, " prev regWrite_memwb"}, 16'(regWrite_memwb), 16'(pend_rw));
    last_memres = pend_val;
    a = t.alu[7:0];
    rdval = mem_model[a];
    pend_val = t.m2r ? rdval : t.alu;
    pend_rw = t.valid & t.rw;
    pend_rd = t.rd;
    if (t.valid & t.mw) mem_model[a] = t.wd;
  endtask

  task automatic stall_phase(input string nm);
    if (cur_memop) begin
      for (int k = 1; k <= WS; k++) begin
        scramble_inputs();
        @(posedge clk); #1;
        check({nm, " wait stall"}, 16'(stall), 16'(k < WS));
        check({nm, " wait regWrite_memwb"}, 16'(regWrite_memwb), 16'h0);
        check({nm, " wait rd_memwb"}, 16'(rd_memwb), 16'h0);
        check({nm, " wait prevMEMRes held"}, prevMEMRes, last_memres);
        check({nm, " wait prevALURes held"}, prevALURes, cur.alu);
        check({nm, " wait rd_exmem held"}, 16'(rd_exmem), 16'(cur.rd));
      end
    end
  endtask

  task automatic issue(input instr_t t, input string nm);
    capture(t, nm);
    stall_phase(nm);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " stall"}, 16'(stall), 16'h0);
    check({nm, " prevALURes"}, prevALURes, 16'h0);
    check({nm, " rd_exmem"}, 16'(rd_exmem), 16'h0);
    check({nm, " regWrite_exmem"}, 16'(regWrite_exmem), 16'h0);
    check({nm, " prevMEMRes"}, prevMEMRes, 16'h0);
    check({nm, " rd_memwb"}, 16'(rd_memwb), 16'h0);
    check({nm, " regWrite_memwb"}, 16'(regWrite_memwb), 16'h0);
  endtask

  instr_t nop;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved;
    instr_t      t;
    for (int i = 0; i < (1 << DL); i++) mem_model[i] = 16'h0000;
    nop = mk(1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pend_rw = 1'b0; pend_rd = '0; pend_val = '0; last_memres = '0;
    cur = nop; cur_memop = 1'b0;
    reset = 1'b1;
    apply(nop);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Pass-through ALU result
    issue(mk(1'b1, 16'h1234, 16'h0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), "passthru");
    issue(nop, "passthru_wb");
    check("passthru prevMEMRes", prevMEMRes, 16'h1234);

    // Store then load the same address
    issue(mk(1'b1, 16'h0010, 16'hBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), "store10");
    issue(mk(1'b1, 16'h0010, 16'h0000, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1), "load10");
    issue(nop, "load10_wb");
    check("load10 value", prevMEMRes, 16'hBEEF);

    // Address wrap
    issue(mk(1'b1, 16'h0105, 16'hA5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), "store_wrap");
    issue(mk(1'b1, 16'h0005, 16'h0000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), "load_wrap");
    issue(nop, "load_wrap_wb");
    check("wrap value", prevMEMRes, 16'hA5A5);

    // Bubble carrying store/regWrite controls must have no effect
    issue(mk(1'b0, 16'h0004, 16'hFFFF, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0), "bubble");
    issue(mk(1'b1, 16'h0004, 16'h0000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1), "load4");
    issue(nop, "load4_wb");
    check("bubble mem4 unchanged", prevMEMRes, 16'h0000);

    // Both read and write set: store happens, read returns old data
    issue(mk(1'b1, 16'h0010, 16'h1111, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1), "rmw");
    issue(nop, "rmw_wb");
    check("rmw old value", prevMEMRes, 16'hBEEF);

    // Reset one edge into the stall of a store
    saved = mem_model[8'h20];
    capture(mk(1'b1, 16'h0020, 16'h7777, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), "store20");
    mem_model[8'h20] = saved;
    reset = 1'b1;
    scramble_inputs();
    @(posedge clk); #1;
    check_all_zero("midstall_reset");
    reset = 1'b0;
    pend_rw = 1'b0; pend_rd = '0; pend_val = '0;
    issue(mk(1'b1, 16'h0020, 16'h0000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1), "load20");
    issue(nop, "load20_wb");
    check("discarded store", prevMEMRes, 16'h0000);

    // Random instruction stream against the model
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      t.valid = ($urandom_range(0, 7) != 0);
      t.alu   = {8'($urandom), 4'h0, 4'($urandom)};
      t.wd    = 16'($urandom);
      t.rd    = 5'($urandom);
      t.rw    = 1'($urandom);
      t.mr    = (kind == 1) || (kind == 3);
      t.mw    = (kind == 2) || (kind == 3);
      t.m2r   = (kind == 1) ? 1'b1 : 1'($urandom);
      issue(t, "rand");
    end
    issue(nop, "final_flush");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
